bcd_mod_counter: RTL and testbench
==================================

Name: bcd_mod_counter

Overview:
Parametrised multi-digit BCD counter with a programmable count range, up/down direction, count enable, synchronous preset load with validity checking, and a cascade carry output. It is the generic successor of the single-decade counter in the digital clock datapath. One instance per clock field: seconds (00-59), minutes (00-59), hours (00-23 or 01-12). Instances chain through carry_out -> en.

Parameters:
DIGITS, 2, number of BCD digits; q and pst are 4*DIGITS bits wide.
MIN_VAL, 0, lowest count value (decimal); 0 <= MIN_VAL < MAX_VAL.
MAX_VAL, 59, highest count value (decimal); MAX_VAL <= 10^DIGITS - 1.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
clr  input  1  synchronous active-high reset.
en  input  1  count enable; one step per rising edge while high.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous preset-load request.
pst  input  4*DIGITS  BCD preset value; digit 0 is bits [3:0].
q  output  4*DIGITS  registered BCD count.
carry_out  output  1  combinational terminal-count pulse for cascading.
load_err  output  1  registered sticky flag: last load request was rejected.

Behaviour:
- Reset: clr=1 at a rising edge sets q = BCD(MIN_VAL) and load_err = 0. clr overrides load and en in the same cycle. Reset asserted mid-count takes effect at that edge with no partial update.
- Priority at each rising edge: clr > load > en > hold.
- Load validity: pst is valid only if every nibble is <= 9 and the decimal value v satisfies MIN_VAL <= v <= MAX_VAL.
  - Valid load: q <= pst and load_err <= 0.
  - Invalid load: q holds and load_err <= 1.
  - load_err stays set until clr or the next valid load. Plain counting does not change load_err.
- Load while en=1: the load wins and no count step occurs in that cycle.
- Count up (en=1, up=1):
  - If q == MAX_VAL, q <= MIN_VAL (wrap).
  - Otherwise BCD increment: digit 0 adds 1. A digit at 9 becomes 0 and carries into the next digit; the carry ripples through all DIGITS.
- Count down (en=1, up=0):
  - If q == MIN_VAL, q <= MAX_VAL (wrap).
  - Otherwise BCD decrement: digit 0 subtracts 1. A digit at 0 becomes 9 and borrows from the next digit.
- Latency: q reflects a count, load or reset one clock after the qualifying edge. There is no pipelining; a new step is accepted every cycle.
- carry_out = en & ((up & q == MAX_VAL) | (~up & q == MIN_VAL)).
  - Purely combinational, so a downstream stage with en tied to carry_out steps on the same edge as the wrap.
  - It is not gated by load or clr, so a downstream stage may step in a cycle where this stage loads or resets.
- en=0: q holds and carry_out = 0.
- Invariant: after reset, q is always valid BCD within [MIN_VAL, MAX_VAL], so out-of-range states are unreachable.
- Parameter checks: elaboration fails if MIN_VAL >= MAX_VAL, if MAX_VAL >= 10^DIGITS, or if DIGITS < 1.
- Width rule: all range comparisons are done on the BCD encoding of MIN_VAL and MAX_VAL, computed at elaboration. There is no runtime binary conversion.

Test Plan:
1. Reset: defaults; count to q=0x23, then assert clr with en=1 and load=1 -> next edge q=0x00, load_err=0, carry_out=0.
2. Up wrap and digit carry: defaults, load 0x08, en=1, up=1 -> q sequence 0x09, 0x10, …; from 0x58 -> 0x59, where carry_out=1 in that cycle -> next 0x00 with carry_out=0.
3. Down wrap and digit borrow: defaults, load 0x10, up=0 -> 0x09; at q=0x00 carry_out=1 -> next 0x59.
4. Load checks: load 0x37 -> q=0x37, load_err=0. Load 0x6A (bad nibble) -> q stays 0x37, load_err=1. Load 0x60 (out of range) -> q stays 0x37, load_err=1. Load 0x15 -> q=0x15, load_err=0.
5. Custom range: MIN_VAL=1, MAX_VAL=12; reset -> q=0x01. Count up through 0x09, 0x10, 0x11, 0x12 (carry_out=1), then 0x01. Counting down from 0x01 gives 0x12. Load 0x00 sets load_err=1.
6. Cascade: two instances (sec -> min, defaults), sec.carry_out drives min.en; start at 0x59:0x59 -> next edge 0x00:0x00; min steps only on sec wraps; en toggled low holds both stages.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD counter over a programmable [MIN_VAL, MAX_VAL] range with
// up/down stepping, checked preset load and a combinational cascade carry.

module bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  input  logic [3:0] p,
  output logic [3:0] nd,
  output logic       cout,
  output logic       p_ok
);
  // cin is the carry (up) or borrow (down) arriving from the lower digit
  always_comb begin
    nd   = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d == 4'd9) begin
          nd   = 4'd0;
          cout = 1'b1;
        end else begin
          nd = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nd   = 4'd9;
          cout = 1'b1;
        end else begin
          nd = d - 4'd1;
        end
      end
    end
  end

  assign p_ok = (p <= 4'd9);
endmodule

module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   pst,
  output logic [4*DIGITS-1:0]   q,
  output logic                  carry_out,
  output logic                  load_err
);
  localparam int W = 4 * DIGITS;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r;
    longint       t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(longint'(MIN_VAL));
  localparam logic [W-1:0] MAX_BCD = to_bcd(longint'(MAX_VAL));

  if (DIGITS < 1) begin : g_bad_digits
    $fatal(1, "bcd_mod_counter: DIGITS must be at least 1");
  end
  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_bad_range
    $fatal(1, "bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL");
  end
  if (longint'(MAX_VAL) >= pow10(DIGITS)) begin : g_bad_max
    $fatal(1, "bcd_mod_counter: MAX_VAL does not fit in DIGITS");
  end

  logic [DIGITS-1:0][3:0] qd, pd, nd;
  logic [DIGITS-1:0]      cin, cout, p_ok;

  assign qd = q;
  assign pd = pst;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .d    (qd[i]),
      .up   (up),
      .cin  (cin[i]),
      .p    (pd[i]),
      .nd   (nd[i]),
      .cout (cout[i]),
      .p_ok (p_ok[i])
    );
    if (i == 0) begin : g_lsd
      assign cin[i] = 1'b1;
    end else begin : g_chain
      assign cin[i] = cout[i-1];
    end
  end

  // Valid BCD orders the same as its decimal value, so plain compares work
  logic ge_min, le_max, pst_ok;
  if (MIN_VAL == 0) begin : g_min_zero
    assign ge_min = 1'b1;
  end else begin : g_min_cmp
    assign ge_min = (pst >= MIN_BCD);
  end
  assign le_max = (pst <= MAX_BCD);
  assign pst_ok = (&p_ok) & ge_min & le_max;

  logic at_max, at_min, at_term, wrap;
  assign at_max  = (q == MAX_BCD);
  assign at_min  = (q == MIN_BCD);
  assign at_term = up ? at_max : at_min;
  // a full-width rollover can only coincide with the terminal value; wrap anyway
  assign wrap    = at_term | cout[DIGITS-1];

  assign carry_out = en & at_term;

  always_ff @(posedge clk) begin
    if (clr) begin
      q        <= MIN_BCD;
      load_err <= 1'b0;
    end else if (load) begin
      if (pst_ok) begin
        q        <= pst;
        load_err <= 1'b0;
      end else begin
        load_err <= 1'b1;
      end
    end else if (en) begin
      q <= wrap ? (up ? MIN_BCD : MAX_BCD) : nd;
    end
  end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: vector table, random run against an integer
// model, custom 1..12 range, and a seconds->minutes cascade.

module tb_bcd_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit pst_valid(input logic [7:0] b, input int lo, input int hi);
    int v;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 1'b0;
    v = bcd2int(b);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic int next_val(input int v, input bit dir_up, input int lo, input int hi);
    if (dir_up) return (v == hi) ? lo : v + 1;
    else        return (v == lo) ? hi : v - 1;
  endfunction

  // default instance, 00..59
  logic       clr, en, up, load;
  logic [7:0] pst, q;
  logic       co, err;
  bcd_mod_counter dut (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .pst(pst),
    .q(q), .carry_out(co), .load_err(err)
  );

  // 01..12 instance
  logic       c_clr, c_en, c_up, c_load;
  logic [7:0] c_pst, c_q;
  logic       c_co, c_err;
  bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12)) dut_c (
    .clk(clk), .clr(c_clr), .en(c_en), .up(c_up), .load(c_load), .pst(c_pst),
    .q(c_q), .carry_out(c_co), .load_err(c_err)
  );

  // seconds -> minutes cascade
  logic       s_clr, s_en, s_up, s_load;
  logic [7:0] s_pst, sec_q, min_q;
  logic       sec_co, min_co, sec_err, min_err;
  bcd_mod_counter u_sec (
    .clk(clk), .clr(s_clr), .en(s_en), .up(s_up), .load(s_load), .pst(s_pst),
    .q(sec_q), .carry_out(sec_co), .load_err(sec_err)
  );
  bcd_mod_counter u_min (
    .clk(clk), .clr(s_clr), .en(sec_co), .up(s_up), .load(s_load), .pst(s_pst),
    .q(min_q), .carry_out(min_co), .load_err(min_err)
  );

  typedef struct {
    logic       clr, en, up, load;
    logic [7:0] pst;
    logic [7:0] q;
    logic       err;
    logic       co;
  } vec_t;

  vec_t tbl[32];

  initial begin
    int mq, me, sv, mv;
    logic exp_co;

    clr = 0; en = 0; up = 1; load = 0; pst = 0;
    c_clr = 0; c_en = 0; c_up = 1; c_load = 0; c_pst = 0;
    s_clr = 0; s_en = 0; s_up = 1; s_load = 0; s_pst = 0;

    //          clr en up ld pst      q      err co (co seen before the edge)
    tbl[0]  = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 8'h20, 8'h20, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 8'h00, 8'h21, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 8'h00, 8'h22, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 8'h00, 8'h23, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, 8'h45, 8'h00, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 8'h08, 8'h08, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 8'h00, 8'h09, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 8'h00, 8'h10, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 8'h58, 8'h58, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 8'h00, 8'h59, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 8'h00, 8'h00, 0, 1};
    tbl[12] = '{0, 1, 1, 0, 8'h00, 8'h01, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 8'h10, 8'h10, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 8'h00, 8'h09, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 8'h01, 8'h01, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0};
    tbl[17] = '{0, 1, 0, 0, 8'h00, 8'h59, 0, 1};
    tbl[18] = '{0, 1, 0, 0, 8'h00, 8'h58, 0, 0};
    tbl[19] = '{0, 0, 1, 1, 8'h37, 8'h37, 0, 0};
    tbl[20] = '{0, 0, 1, 1, 8'h6A, 8'h37, 1, 0};
    tbl[21] = '{0, 0, 1, 1, 8'h60, 8'h37, 1, 0};
    tbl[22] = '{0, 1, 1, 0, 8'h00, 8'h38, 1, 0};
    tbl[23] = '{0, 0, 1, 1, 8'h15, 8'h15, 0, 0};
    tbl[24] = '{0, 0, 1, 1, 8'h6A, 8'h15, 1, 0};
    tbl[25] = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 0};
    tbl[26] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0};
    tbl[27] = '{0, 1, 0, 1, 8'h42, 8'h42, 0, 1};
    tbl[28] = '{0, 0, 1, 1, 8'h0F, 8'h42, 1, 0};
    tbl[29] = '{0, 0, 1, 1, 8'hA0, 8'h42, 1, 0};
    tbl[30] = '{0, 1, 1, 1, 8'h59, 8'h59, 0, 0};
    tbl[31] = '{0, 0, 1, 0, 8'h00, 8'h59, 0, 0};

    // initialise the other instances alongside the table's first reset
    c_clr = 1; s_clr = 1;
    #1;
    for (int i = 0; i < 32; i++) begin
      clr = tbl[i].clr; en = tbl[i].en; up = tbl[i].up;
      load = tbl[i].load; pst = tbl[i].pst;
      #1;
      chk($sformatf("vec%0d carry_out", i), co, tbl[i].co);
      tick();
      c_clr = 0; s_clr = 0;
      chk($sformatf("vec%0d q", i), q, tbl[i].q);
      chk($sformatf("vec%0d load_err", i), err, tbl[i].err);
    end

    // random run against the integer model
    clr = 1; en = 0; load = 0;
    tick();
    mq = 0; me = 0;
    chk("rand reset q", q, 8'h00);
    for (int n = 0; n < 400; n++) begin
      clr  = ($urandom_range(0, 99) < 3);
      load = ($urandom_range(0, 5) == 0);
      pst  = $urandom_range(0, 1) ? int2bcd($urandom_range(0, 59)) : 8'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1);
      #1;
      exp_co = en & ((up & (mq == 59)) | (~up & (mq == 0)));
      chk("rand carry_out", co, exp_co);
      if (clr) begin
        mq = 0; me = 0;
      end else if (load) begin
        if (pst_valid(pst, 0, 59)) begin
          mq = bcd2int(pst); me = 0;
        end else begin
          me = 1;
        end
      end else if (en) begin
        mq = next_val(mq, up, 0, 59);
      end
      tick();
      chk("rand q", q, int2bcd(mq));
      chk("rand load_err", err, me);
    end
    clr = 0; en = 0; load = 0;

    // custom 01..12 range
    c_clr = 1;
    tick();
    c_clr = 0;
    chk("c reset q", c_q, 8'h01);
    chk("c reset load_err", c_err, 0);
    c_en = 1; c_up = 1;
    for (int k = 2; k <= 12; k++) begin
      tick();
      chk($sformatf("c up %0d", k), c_q, int2bcd(k));
    end
    chk("c carry at 12", c_co, 1);
    tick();
    chk("c wrap to 01", c_q, 8'h01);
    c_up = 0;
    #1;
    chk("c carry at 01 down", c_co, 1);
    tick();
    chk("c down wrap to 12", c_q, 8'h12);
    c_en = 0; c_load = 1; c_pst = 8'h00;
    tick();
    chk("c load 00 err", c_err, 1);
    chk("c load 00 q hold", c_q, 8'h12);
    c_pst = 8'h13;
    tick();
    chk("c load 13 err", c_err, 1);
    c_pst = 8'h07;
    tick();
    chk("c load 07 q", c_q, 8'h07);
    chk("c load 07 err", c_err, 0);
    c_load = 0;

    // cascade from 59:59
    s_load = 1; s_pst = 8'h59; s_en = 0;
    tick();
    s_load = 0;
    chk("cas preload sec", sec_q, 8'h59);
    chk("cas preload min", min_q, 8'h59);
    s_en = 1; s_up = 1;
    #1;
    chk("cas sec carry", sec_co, 1);
    chk("cas min carry", min_co, 1);
    tick();
    chk("cas wrap sec", sec_q, 8'h00);
    chk("cas wrap min", min_q, 8'h00);
    sv = 0; mv = 0;
    for (int n = 0; n < 150; n++) begin
      s_en = ($urandom_range(0, 9) < 7);
      #1;
      chk("cas sec carry_out", sec_co, s_en & (sv == 59));
      if (s_en) begin
        if (sv == 59) mv = next_val(mv, 1'b1, 0, 59);
        sv = next_val(sv, 1'b1, 0, 59);
      end
      tick();
      chk("cas sec q", sec_q, int2bcd(sv));
      chk("cas min q", min_q, int2bcd(mv));
    end
    s_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
